// File: rtl/regfile_dbg_pkg.sv
// Shared types and sizing constants for the register-file debug dump path.
package regfile_dbg_pkg;

  localparam int RF_ADDR_WIDTH = 5;
  localparam int RF_DATA_WIDTH = 32;
  localparam int RF_NUM_REGS   = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    PRESENT = 2'd3
  } dump_state_e;

endpackage

// File: rtl/regfile_dump_reader.sv
// Walks register-file read port A over [FIRST_REG, LAST_REG] and streams each
// word out on a valid/ready channel; owns rf_addr only while busy.
module regfile_dump_reader
  import regfile_dbg_pkg::*;
#(
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int FIRST_REG  = 0,
  parameter int LAST_REG   = 31
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rf_addr,
  input  logic [DATA_WIDTH-1:0] rf_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_index,
  output dump_state_e           dbg_state
);

  // Output channel: a word transfers on a posedge where out_valid && out_ready.
  // out_data/out_index never change while out_valid is high and out_ready low.

  generate
    if (FIRST_REG > LAST_REG) begin : g_bad_range
      $error("regfile_dump_reader: FIRST_REG must not exceed LAST_REG");
    end
    if (LAST_REG >= (1 << ADDR_WIDTH)) begin : g_bad_width
      $error("regfile_dump_reader: LAST_REG does not fit in ADDR_WIDTH");
    end
  endgenerate

  localparam logic [ADDR_WIDTH-1:0] FIRST_IDX = ADDR_WIDTH'(FIRST_REG);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(LAST_REG);

  dump_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [ADDR_WIDTH-1:0] out_index_q, out_index_d;
  logic                  out_valid_q, out_valid_d;
  logic                  done_q, done_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= FIRST_IDX;
      out_data_q  <= '0;
      out_index_q <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          idx_d   = FIRST_IDX;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = abort ? IDLE : CAPTURE;
      end
      CAPTURE: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          out_data_d  = rf_data;
          out_index_d = idx_q;
          out_valid_d = 1'b1;
          state_d     = PRESENT;
        end
      end
      PRESENT: begin
        // Abort wins over a same-cycle handshake: the word is dropped.
        if (abort) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + ADDR_WIDTH'(1);
            state_d = ISSUE;
          end
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign rf_addr   = idx_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_index = out_index_q;
  assign dbg_state = state_q;

endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
- Sequential reader that drives the register file's A read port and streams a contiguous range of registers out over a valid/ready interface.
- Used by the debug/trace path to snapshot CPU architectural state after halt.
- Sits between the register file (synchronous read: address sampled at posedge, data valid the following cycle) and the debug output channel.
- Owns the read-port address only while busy. The top level muxes the CPU's Aa with rf_addr using busy.

Parameters:
- DATA_WIDTH, 32, width of a register word.
- ADDR_WIDTH, 5, register address width.
- FIRST_REG, 0, first register index dumped.
- LAST_REG, 31, last register index dumped. Must satisfy FIRST_REG <= LAST_REG, checked by elaboration-time assertion.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  begin a dump. Sampled only in IDLE.
- abort  input  1  synchronous cancel of a dump in progress.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the final word's handshake.
- rf_addr  output  ADDR_WIDTH  register file read address, driven to the Aa port.
- rf_data  input  DATA_WIDTH  register file read data, taken from Da.
- out_valid  output  1  out_data and out_index are valid.
- out_ready  input  1  consumer accepts the word when out_valid && out_ready at a posedge.
- out_data  output  DATA_WIDTH  register contents.
- out_index  output  ADDR_WIDTH  register number of out_data.

Behaviour:
- Reset (asynchronous, any state):
  - Outputs: state=IDLE, busy=0, done=0, out_valid=0, out_data=0, out_index=0.
  - Internal: idx=FIRST_REG, so rf_addr=FIRST_REG.
- rf_addr is always driven from the registered idx. It is glitch-free and stable for the whole per-word sequence.
- State IDLE:
  - busy=0.
  - start=1 → ISSUE, with idx=FIRST_REG.
- State ISSUE (1 cycle):
  - rf_addr=idx is presented. The register file samples it at the end of this cycle.
  - Next state: CAPTURE.
- State CAPTURE (1 cycle):
  - rf_data is now valid for idx.
  - At the posedge: out_data<=rf_data, out_index<=idx, out_valid<=1.
  - Next state: PRESENT.
- State PRESENT:
  - out_valid=1. out_data and out_index are held stable until the handshake. They must not change while valid && !ready.
  - On handshake with idx==LAST_REG: out_valid<=0, done<=1 for one cycle, go to IDLE.
  - On handshake with idx!=LAST_REG: out_valid<=0, idx<=idx+1, go to ISSUE.
- Throughput: 3 cycles per word minimum when out_ready is held high. Each stall cycle in PRESENT adds 1 cycle. A full 32-register dump with ready held high takes 96 cycles from start to done.
- Latency: the first out_valid rises at the 2nd posedge after start is sampled.
- abort=1 in any busy state:
  - Next state is IDLE and out_valid<=0. idx stays where it was (next start resets it).
  - done is not asserted.
  - abort takes priority over a same-cycle handshake; that word counts as not delivered.
- start while busy is ignored. start and abort together in IDLE: abort wins, stay IDLE.
- done and start in the same cycle: start is legal because the state is already IDLE, so a back-to-back dump begins.
- idx arithmetic: width ADDR_WIDTH. idx never increments past LAST_REG, so no wrap occurs. LAST_REG=31 with ADDR_WIDTH=5 must not wrap to 0.
- FIRST_REG==LAST_REG produces exactly one word, then done.
- Coherence: the block does not block register file writes. The top level must hold the CPU (WrEn=0) while busy. A same-cycle write to idx returns the pre-write value, per the register file's read-before-write timing.

Decomposition:
- Shared package regfile_dbg_pkg holds:
  - state enum {IDLE, ISSUE, CAPTURE, PRESENT}, 2 bits;
  - constants RF_ADDR_WIDTH=5, RF_DATA_WIDTH=32, RF_NUM_REGS=32.
- Single module, no sub-module. The output holding register is small enough to stay inline.

Test Plan:
- Reset mid-PRESENT with out_ready=0 → next cycle busy=0, out_valid=0, rf_addr=0, done never pulses.
- Preload r5=0xDEADBEEF, r31=0x12345678; pulse start with out_ready=1 → 32 words with out_index 0..31 in order, word5=0xDEADBEEF, word31=0x12345678, word0=0, done pulses exactly once at cycle 96.
- Same preload with out_ready toggling 1,0,0,1 per cycle → out_data/out_index are held stable whenever valid && !ready, all 32 words are delivered exactly once, no duplicates.
- abort asserted during CAPTURE of index 7 → out_valid never rises for index 7, busy drops next cycle, no done; a new start then dumps from index 0.
- FIRST_REG=LAST_REG=31 → exactly one word (index 31), done 1 cycle after handshake, idx does not wrap.
- start held high for 200 cycles → a back-to-back dump restarts in the cycle after each done, with no start re-triggered while busy.
